bcd_updown_counter: RTL

Parametrised, registered multi-digit BCD counter; the sequential successor to the combinational 3-digit BCD incrementor. Counts up or down by one decimal unit per enabled clock. Supports synchronous clear and parallel load, and selects wrap or saturate at the range limits. Used as a decimal event/tick counter feeding seven-segment display drivers and decimal timers.

---
 rtl/bcd_updown_counter.sv | 117 +++++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// Registered multi-digit BCD up/down counter with synchronous clear, checked
// parallel load, and wrap or saturate behaviour at the range limits.
module bcd_updown_counter #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] q,
  output logic                ovf,
  output logic                unf,
  output logic                err,
  output logic                is_max,
  output logic                is_zero
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0]      q_reg, q_next;
  logic [W-1:0]      inc_val, dec_val;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              err_reg, err_next;
  logic [DIGITS-1:0] nine_vec, zero_vec, din_ok_vec;
  logic              din_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur_digit;
      logic [3:0] din_digit;
      logic       carry_in;
      logic       borrow_in;

      assign cur_digit       = q_reg[4*gi +: 4];
      assign din_digit       = din[4*gi +: 4];
      assign nine_vec[gi]    = (cur_digit == 4'd9);
      assign zero_vec[gi]    = (cur_digit == 4'd0);
      assign din_ok_vec[gi]  = (din_digit <= 4'd9);

      // A digit steps only when every lower digit is at its roll-over value.
      if (gi == 0) begin : g_lsd
        assign carry_in  = 1'b1;
        assign borrow_in = 1'b1;
      end else begin : g_upper
        assign carry_in  = &nine_vec[gi-1:0];
        assign borrow_in = &zero_vec[gi-1:0];
      end

      assign inc_val[4*gi +: 4] = !carry_in ? cur_digit :
                                  (nine_vec[gi] ? 4'd0 : cur_digit + 4'd1);
      assign dec_val[4*gi +: 4] = !borrow_in ? cur_digit :
                                  (zero_vec[gi] ? 4'd9 : cur_digit - 4'd1);
    end
  endgenerate

  assign din_valid = &din_ok_vec;
  assign is_max    = &nine_vec;
  assign is_zero   = &zero_vec;

  always_comb begin
    q_next   = q_reg;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    err_next = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      if (din_valid) begin
        q_next = din;
      end else begin
        err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (is_max) begin
          ovf_next = 1'b1;
          q_next   = SATURATE ? ALL_NINES : '0;
        end else begin
          q_next = inc_val;
        end
      end else begin
        if (is_zero) begin
          unf_next = 1'b1;
          q_next   = SATURATE ? '0 : ALL_NINES;
        end else begin
          q_next = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
      err_reg <= err_next;
    end
  end

  assign q   = q_reg;
  assign ovf = ovf_reg;
  assign unf = unf_reg;
  assign err = err_reg;

endmodule
